// File: rtl/pe_stream_sequencer_if.sv
// Command, operand, PE and result buses of the PE stream sequencer, plus busy/done status.
// The slave modport is the sequencer's view; the master modport is the command source / PE side.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef MODE_MAC
`define MODE_MAC 2'd0
`endif
`ifndef MODE_MUL
`define MODE_MUL 2'd1
`endif
`ifndef MODE_ADD
`define MODE_ADD 2'd2
`endif

interface pe_stream_sequencer_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  opd_valid;
  logic                  opd_ready;
  logic [DATA_WIDTH-1:0] opd_a;
  logic [DATA_WIDTH-1:0] opd_b;
  logic [1:0]            pe_op_mode;
  logic                  pe_clear_acc;
  logic [DATA_WIDTH-1:0] pe_in_A;
  logic [DATA_WIDTH-1:0] pe_in_B;
  logic [DATA_WIDTH-1:0] pe_out_val;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  busy;
  logic                  done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, opd_valid, opd_a, opd_b, pe_out_val, res_ready,
    output cmd_ready, opd_ready, pe_op_mode, pe_clear_acc, pe_in_A, pe_in_B,
           res_valid, res_data, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_len, opd_valid, opd_a, opd_b, pe_out_val, res_ready,
    input  cmd_ready, opd_ready, pe_op_mode, pe_clear_acc, pe_in_A, pe_in_B,
           res_valid, res_data, busy, done
  );
endinterface

// File: rtl/pe_stream_sequencer.sv
// Sequences DOT/MUL/ADD commands through a registered PE; element results land in a 4-deep FWFT FIFO 2 edges after accept.
// Operands stall whenever queued plus in-flight results would reach 4; a final DOT result waits for FIFO space.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef MODE_MAC
`define MODE_MAC 2'd0
`endif
`ifndef MODE_MUL
`define MODE_MUL 2'd1
`endif
`ifndef MODE_ADD
`define MODE_ADD 2'd2
`endif

module pe_stream_sequencer #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int LEN_WIDTH  = 8
) (
  input logic clk,
  input logic reset,
  pe_stream_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN} state_t;

  localparam logic [1:0] OP_DOT = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_op;
  logic                  r_bypass;
  logic                  r_zero_push;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_d1;
  logic                  r_d2;
  logic [DATA_WIDTH-1:0] r_pe_a;
  logic [DATA_WIDTH-1:0] r_pe_b;
  logic [DATA_WIDTH-1:0] r_mem [0:3];
  logic [1:0]            r_wp;
  logic [1:0]            r_rp;
  logic [2:0]            r_count;

  logic                  w_cmd_fire;
  logic                  w_opd_fire;
  logic                  w_opd_ready;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_push_dat;
  logic [2:0]            w_inflight;
  logic                  w_is_ew;
  logic                  w_not_full;

  // r_d1/r_d2 trace each accepted pair through the PE: r_d2 marks the cycle its result sits on pe_out_val.
  assign w_inflight  = {2'b0, r_d1} + {2'b0, r_d2};
  assign w_is_ew     = (r_op == OP_MUL) || (r_op == OP_ADD);
  assign w_not_full  = (r_count != 3'd4);
  assign w_opd_ready = (r_state == S_RUN) && (r_remaining != '0) && ((r_count + w_inflight) < 3'd4);
  assign w_cmd_fire  = bus.cmd_valid && (r_state == S_IDLE);
  assign w_opd_fire  = bus.opd_valid && w_opd_ready;
  assign w_pop       = (r_count != 3'd0) && bus.res_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_push      = 1'b0;
    w_push_dat  = bus.pe_out_val;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          w_state_nxt = ((bus.cmd_len != '0) && (bus.cmd_op != OP_RSV)) ? S_CLEAR : S_DRAIN;
        end
      end
      S_CLEAR: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_opd_fire && (r_remaining == LEN_ONE)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_bypass) begin
          if (!r_zero_push || w_not_full) begin
            w_push      = r_zero_push;
            w_push_dat  = '0;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (!w_is_ew) begin
          // Once the last pair has left r_d1 the PE accumulator holds the final sum.
          if (!r_d1 && w_not_full) begin
            w_push      = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_inflight == 3'd0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_is_ew && r_d2) w_push = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_DOT;
      r_bypass    <= 1'b0;
      r_zero_push <= 1'b0;
      r_remaining <= '0;
      r_d1        <= 1'b0;
      r_d2        <= 1'b0;
      r_pe_a      <= '0;
      r_pe_b      <= '0;
      r_wp        <= 2'd0;
      r_rp        <= 2'd0;
      r_count     <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_fire) begin
        r_op        <= bus.cmd_op;
        r_remaining <= bus.cmd_len;
        r_bypass    <= (bus.cmd_len == '0) || (bus.cmd_op == OP_RSV);
        r_zero_push <= (bus.cmd_len == '0) && (bus.cmd_op == OP_DOT);
      end else if (w_opd_fire) begin
        r_remaining <= r_remaining - LEN_ONE;
      end
      r_d1    <= w_opd_fire;
      r_d2    <= r_d1;
      r_pe_a  <= w_opd_fire ? bus.opd_a : '0;
      r_pe_b  <= w_opd_fire ? bus.opd_b : '0;
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      r_count <= r_count + {2'b0, w_push} - {2'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_push_dat;
  end

  always_comb begin
    bus.pe_op_mode = `MODE_MAC;
    if (r_state != S_IDLE) begin
      case (r_op)
        OP_MUL:  bus.pe_op_mode = `MODE_MUL;
        OP_ADD:  bus.pe_op_mode = `MODE_ADD;
        default: bus.pe_op_mode = `MODE_MAC;
      endcase
    end
  end

  assign bus.cmd_ready    = (r_state == S_IDLE);
  assign bus.opd_ready    = w_opd_ready;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = w_done;
  assign bus.pe_clear_acc = reset || (r_state == S_CLEAR);
  assign bus.pe_in_A      = r_pe_a;
  assign bus.pe_in_B      = r_pe_b;
  assign bus.res_valid    = (r_count != 3'd0);
  assign bus.res_data     = r_mem[r_rp];
endmodule

// File: tb/tb_pe_stream_sequencer.sv
// Bench for pe_stream_sequencer: directed and random command streams scored against a queue of expected results.
// A small saturating Q3.12 PE model closes the loop on pe_in_A/B -> pe_out_val.
`ifndef MODE_MAC
`define MODE_MAC 2'd0
`endif
`ifndef MODE_MUL
`define MODE_MUL 2'd1
`endif
`ifndef MODE_ADD
`define MODE_ADD 2'd2
`endif

module tb_pe_stream_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pe_stream_sequencer_if #(.DATA_WIDTH(16), .LEN_WIDTH(8)) sif ();
  pe_stream_sequencer #(.DATA_WIDTH(16), .LEN_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(sif.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int s2i(input logic [15:0] x);
    int r;
    r = $signed(x);
    return r;
  endfunction

  function automatic logic [15:0] sat16(input int v);
    logic [31:0] t;
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    t = v;
    return t[15:0];
  endfunction

  function automatic int prod(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = s2i(a) * s2i(b);
    return p >>> 12;
  endfunction

  // PE: one registered result, accumulator cleared on pe_clear_acc.
  logic [15:0] pe_acc;
  always @(posedge clk) begin
    if (sif.pe_clear_acc) pe_acc <= 16'h0000;
    else begin
      case (sif.pe_op_mode)
        `MODE_MAC: pe_acc <= sat16(s2i(pe_acc) + prod(sif.pe_in_A, sif.pe_in_B));
        `MODE_MUL: pe_acc <= sat16(prod(sif.pe_in_A, sif.pe_in_B));
        `MODE_ADD: pe_acc <= sat16(s2i(sif.pe_in_A) + s2i(sif.pe_in_B));
        default:   pe_acc <= pe_acc;
      endcase
    end
  end
  assign sif.pe_out_val = pe_acc;

  logic [15:0] exp_q[$];
  logic [15:0] opa[$];
  logic [15:0] opb[$];
  int done_cnt = 0, clear_cnt = 0, res_cnt = 0, cyc = 0;
  int first_rv_cyc = -1, first_acc_cyc = 0, last_acc_cyc = 0;
  int rr_pct = 100;
  logic lat_arm = 1'b0;
  logic prev_done = 1'b0;
  logic [15:0] last_res = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (sif.done) begin
        done_cnt++;
        check_eq("done_width", 32'(prev_done), 32'd0);
      end
      if (sif.pe_clear_acc) clear_cnt++;
      if (lat_arm && sif.res_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
      if (sif.res_valid && sif.res_ready) begin
        res_cnt++;
        last_res = sif.res_data;
        if (exp_q.size() == 0) check_eq("spurious_result", 32'(exp_q.size()), 32'd1);
        else check_eq("res_data", 32'(sif.res_data), 32'(exp_q.pop_front()));
      end
    end
    prev_done = sif.done;
  end

  initial begin
    sif.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sif.res_ready = ($urandom_range(99) < rr_pct);
    end
  end

  // Expected results of a whole command, straight from the command rules.
  task automatic model_cmd(input logic [1:0] op, input int len);
    int acc;
    if (op == 2'd3) return;
    if (op == 2'd0) begin
      acc = 0;
      for (int i = 0; i < len; i++) acc = s2i(sat16(acc + prod(opa[i], opb[i])));
      exp_q.push_back(sat16(acc));
    end else begin
      for (int i = 0; i < len; i++)
        exp_q.push_back(op == 2'd1 ? sat16(prod(opa[i], opb[i])) : sat16(s2i(opa[i]) + s2i(opb[i])));
    end
  endtask

  task automatic fill_const(input int len, input logic [15:0] a, input logic [15:0] b);
    opa.delete();
    opb.delete();
    for (int i = 0; i < len; i++) begin
      opa.push_back(a);
      opb.push_back(b);
    end
  endtask

  task automatic fill_rand(input int len);
    logic [15:0] va, vb;
    opa.delete();
    opb.delete();
    for (int i = 0; i < len; i++) begin
      va = 16'($urandom);
      vb = 16'($urandom);
      if ($urandom_range(1) == 1) va = {{4{va[11]}}, va[11:0]};
      if ($urandom_range(1) == 1) vb = {{4{vb[11]}}, vb[11:0]};
      opa.push_back(va);
      opb.push_back(vb);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input int len);
    int   guard;
    logic acc;
    guard = 0;
    acc = 1'b0;
    model_cmd(op, len);
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = op;
    sif.cmd_len   = 8'(len);
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = sif.cmd_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    sif.cmd_valid = 1'b0;
    check_eq("cmd_accept", 32'(acc), 32'd1);
  endtask

  task automatic feed(input int len, input int vmode, input int max_cyc, input int start, output int reached);
    int   idx, n;
    logic v;
    idx = start;
    n = 0;
    while (idx < len && n < max_cyc) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (n % 2 == 0) : ($urandom_range(1) == 1);
      sif.opd_valid = v;
      sif.opd_a = v ? opa[idx] : 16'($urandom);
      sif.opd_b = v ? opb[idx] : 16'($urandom);
      @(negedge clk);
      if (sif.opd_valid && sif.opd_ready) begin
        if (idx == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        idx++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    sif.opd_valid = 1'b0;
    sif.opd_a = 16'h0000;
    sif.opd_b = 16'h0000;
    reached = idx;
  endtask

  task automatic wait_done(input int done0);
    int g;
    g = 0;
    while (done_cnt == done0 && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_eq("done_pulses", 32'(done_cnt - done0), 32'd1);
    check_eq("busy_after_done", 32'(sif.busy), 32'd0);
    check_eq("cmd_ready_after_done", 32'(sif.cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input int len, input int vmode);
    int d0, r;
    d0 = done_cnt;
    send_cmd(op, len);
    if (op != 2'd3 && len != 0) begin
      feed(len, vmode, 400, 0, r);
      check_eq("pairs_accepted", 32'(r), 32'(len));
    end
    wait_done(d0);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || sif.res_valid) && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_eq("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r0, d0, clr0;
    sif.cmd_valid = 1'b0;
    sif.cmd_op    = 2'd0;
    sif.cmd_len   = 8'd0;
    sif.opd_valid = 1'b0;
    sif.opd_a     = 16'h0000;
    sif.opd_b     = 16'h0000;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(sif.busy), 32'd0);
    check_eq("rst_done", 32'(sif.done), 32'd0);
    check_eq("rst_res_valid", 32'(sif.res_valid), 32'd0);
    check_eq("rst_opd_ready", 32'(sif.opd_ready), 32'd0);
    check_eq("rst_cmd_ready", 32'(sif.cmd_ready), 32'd1);
    check_eq("rst_mode", 32'(sif.pe_op_mode), 32'(`MODE_MAC));
    check_eq("rst_in_a", 32'(sif.pe_in_A), 32'd0);
    check_eq("rst_in_b", 32'(sif.pe_in_B), 32'd0);
    check_eq("rst_clear", 32'(sif.pe_clear_acc), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_clear", 32'(sif.pe_clear_acc), 32'd0);
    @(posedge clk);
    #1;

    clr0 = clear_cnt;
    fill_const(3, 16'h1000, 16'h2000);
    run_cmd(2'd0, 3, 0);
    wait_drain();
    check_eq("dot3_value", 32'(last_res), 32'h6000);
    check_eq("dot3_clear_cycles", 32'(clear_cnt - clr0), 32'd1);

    fill_const(2, 16'h7FFF, 16'h7FFF);
    run_cmd(2'd0, 2, 2);
    wait_drain();
    check_eq("dot_sat_value", 32'(last_res), 32'h7FFF);

    rr_pct = 0;
    fill_rand(6);
    d0 = done_cnt;
    r0 = res_cnt;
    send_cmd(2'd1, 6);
    feed(6, 0, 20, 0, r);
    check_eq("mul6_stall_pairs", 32'(r), 32'd4);
    check_eq("mul6_stall_opd_ready", 32'(sif.opd_ready), 32'd0);
    check_eq("mul6_stall_no_pop", 32'(res_cnt - r0), 32'd0);
    rr_pct = 100;
    feed(6, 0, 100, 4, r);
    check_eq("mul6_pairs", 32'(r), 32'd6);
    wait_done(d0);
    wait_drain();
    check_eq("mul6_results", 32'(res_cnt - r0), 32'd6);

    r0 = res_cnt;
    fill_const(4, 16'h0100, 16'h0200);
    run_cmd(2'd2, 4, 1);
    wait_drain();
    check_eq("add4_results", 32'(res_cnt - r0), 32'd4);
    check_eq("add4_value", 32'(last_res), 32'h0300);

    clr0 = clear_cnt;
    r0 = res_cnt;
    fill_const(0, 16'h0000, 16'h0000);
    run_cmd(2'd0, 0, 0);
    wait_drain();
    check_eq("dot0_clear_cycles", 32'(clear_cnt - clr0), 32'd0);
    check_eq("dot0_results", 32'(res_cnt - r0), 32'd1);
    check_eq("dot0_value", 32'(last_res), 32'h0000);

    r0 = res_cnt;
    run_cmd(2'd2, 0, 0);
    fill_const(5, 16'h1000, 16'h1000);
    run_cmd(2'd3, 5, 0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("bypass_no_results", 32'(res_cnt - r0), 32'd0);

    rr_pct = 0;
    fill_rand(4);
    run_cmd(2'd1, 4, 0);
    d0 = done_cnt;
    send_cmd(2'd0, 0);
    repeat (6) @(posedge clk);
    #1;
    check_eq("dot0_full_busy", 32'(sif.busy), 32'd1);
    check_eq("dot0_full_no_done", 32'(done_cnt - d0), 32'd0);
    rr_pct = 100;
    wait_done(d0);
    wait_drain();

    fill_rand(5);
    first_rv_cyc = -1;
    lat_arm = 1'b1;
    run_cmd(2'd1, 5, 0);
    lat_arm = 1'b0;
    check_eq("ew_back_to_back", 32'(last_acc_cyc - first_acc_cyc), 32'd4);
    check_eq("ew_latency", 32'(first_rv_cyc - first_acc_cyc), 32'd3);
    wait_drain();

    rr_pct = 0;
    fill_rand(8);
    d0 = done_cnt;
    send_cmd(2'd1, 8);
    feed(8, 0, 6, 0, r);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_eq("midrst_busy", 32'(sif.busy), 32'd0);
    check_eq("midrst_res_valid", 32'(sif.res_valid), 32'd0);
    reset = 1'b0;
    rr_pct = 100;
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    fill_const(1, 16'h1000, 16'h1000);
    run_cmd(2'd0, 1, 0);
    wait_drain();
    check_eq("post_rst_dot1", 32'(last_res), 32'h1000);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] op;
      int len;
      op = 2'($urandom_range(3));
      len = $urandom_range(7);
      rr_pct = $urandom_range(100, 30);
      fill_rand(len);
      run_cmd(op, len, 2);
    end
    rr_pct = 100;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
